// File: rtl/ring_mem_ctrl_if.sv
// Request/response bus between the command decoder and the ring sequencer.
//
// Handshake: a request transfers at the end of any cycle where req_valid and
// req_ready are both 1. The master holds req_we/req_addr/req_wdata stable while
// req_valid is high. The slave holds req_ready low from acceptance until its
// completion pulse has gone by, so at most one request is ever outstanding.
// rsp_valid is a one-cycle pulse; rsp_err and rsp_rdata are qualified by it,
// and rsp_rdata keeps its value until the next read completes.
interface ring_mem_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ring_mem_ctrl.sv
// Sequencer for the recirculating serial word memory. Tracks ring rotation
// with a bit-phase and a word-position counter, streams write data into the
// ring LSB first during the target word's write slot, and captures read data
// when the target word is on the ring's visible output.
module ring_mem_ctrl #(
  parameter int WORD_COUNT  = 20,
  parameter int ADDR_W      = 5,
  parameter int READ_OFFSET = 1
) (
  input  logic              clk,
  input  logic              reset,
  ring_mem_ctrl_if.slave    bus,
  output logic              ring_write,
  output logic              ring_din,
  input  logic [7:0]        ring_q,
  output logic [2:0]        state_dbg,
  output logic [2:0]        phase_dbg,
  output logic [ADDR_W-1:0] rot_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ERR    = 3'd1,
    WAIT_W = 3'd2,
    WRITE  = 3'd3,
    WAIT_R = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ROT_LAST = ADDR_W'(WORD_COUNT - 1);
  localparam logic [ADDR_W:0]   N_EXT    = (ADDR_W + 1)'(WORD_COUNT);
  localparam logic [ADDR_W:0]   OFF_EXT  = (ADDR_W + 1)'(READ_OFFSET);

  state_t            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [ADDR_W-1:0] rot_q, rot_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [7:0]        rsp_rdata_q, rsp_rdata_d;
  logic              ring_write_q, ring_write_d;
  logic              ring_din_q, ring_din_d;

  logic              req_ready;
  logic              accept;
  logic              addr_bad;
  logic              slot_next;
  logic [ADDR_W:0]   rot_off;
  logic              read_hit;

  // Ready only in IDLE and never while reset is held.
  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = bus.req_valid && req_ready;

  // Next-state, counter and output computation for the sequencer.
  always_comb begin
    // Free-running rotation counters.
    phase_d = phase_q + 3'd1;
    rot_d   = rot_q;
    if (phase_q == 3'd7) begin
      rot_d = (rot_q == ROT_LAST) ? '0 : rot_q + 1'b1;
    end

    // Word currently visible on ring_q: (rot + READ_OFFSET) mod N with one
    // conditional subtract (READ_OFFSET is below N).
    rot_off = {1'b0, rot_q} + OFF_EXT;
    if (rot_off >= N_EXT) begin
      rot_off = rot_off - N_EXT;
    end
    read_hit = (rot_off == {1'b0, addr_q});

    addr_bad = ({1'b0, bus.req_addr} >= N_EXT);

    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    slot_next   = 1'b0;

    // The write-slot test looks one cycle ahead (next phase 0, next rot equal
    // to the address) so that the registered ring_write is high in exactly
    // the eight cycles of the slot. Done from IDLE too, so that a slot
    // starting in the cycle right after acceptance is not missed; the FSM
    // then goes straight to WRITE without a WAIT_W cycle.
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (addr_bad) begin
            state_d     = ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (bus.req_we) begin
            slot_next = (phase_q == 3'd7) && (rot_d == bus.req_addr);
            state_d   = slot_next ? WRITE : WAIT_W;
          end else begin
            state_d = WAIT_R;
          end
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      WAIT_W: begin
        slot_next = (phase_q == 3'd7) && (rot_d == addr_q);
        if (slot_next) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (phase_q == 3'd7) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
        end
      end
      WAIT_R: begin
        if (read_hit) begin
          rsp_rdata_d = ring_q;
          state_d     = DONE;
          rsp_valid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Direction is carried by the state, so we is not kept separately.
    ring_write_d = (state_d == WRITE);
    ring_din_d   = ring_write_d && wdata_d[phase_d];
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= 3'd0;
      rot_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= 8'h00;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 8'h00;
      ring_write_q <= 1'b0;
      ring_din_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      rot_q        <= rot_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      ring_write_q <= ring_write_d;
      ring_din_q   <= ring_din_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign ring_write    = ring_write_q;
  assign ring_din      = ring_din_q;
  assign state_dbg     = state_q;
  assign phase_dbg     = phase_q;
  assign rot_dbg       = rot_q;

endmodule
